// File: rtl/seven_segment_scanner_if.sv
// Display-side bundle of the seven-segment scanner: input word and the anode/segment drive.
// Purely combinational wiring; no latency, no flow control.
// slave = scanner, master = whoever supplies value_in and watches the display pins.
interface seven_segment_scanner_if;
    logic [15:0] value_in;
    logic [3:0]  an;
    logic [6:0]  seg;
    logic        dp;
    logic        frame_start;

    modport master (
        output value_in,
        input  an,
        input  seg,
        input  dp,
        input  frame_start
    );

    modport slave (
        input  value_in,
        output an,
        output seg,
        output dp,
        output frame_start
    );
endinterface

// File: rtl/seven_segment_scanner.sv
// 4-digit common-anode hex scanner with optional leading-zero blanking and per-frame input latch.
// Latency: an/seg registered one clock after idx/shadow; value_in captured on the 3->0 digit edge.
// No backpressure: free-running scan; value_in is sampled once per frame and ignored otherwise.
module seven_segment_scanner #(
    parameter int DIGIT_TICKS   = 40000,
    parameter int BLANK_LEADING = 1
) (
    input  logic                    clk,
    input  logic                    reset,
    seven_segment_scanner_if.slave  disp
);

    localparam int            TW        = (DIGIT_TICKS > 1) ? $clog2(DIGIT_TICKS) : 1;
    localparam logic [TW-1:0] TICK_LAST = TW'(DIGIT_TICKS - 1);

    logic [TW-1:0] tick_cnt_q, tick_cnt_d;
    logic [1:0]    idx_q, idx_d;
    logic [15:0]   shadow_q, shadow_d;
    logic          frame_start_q, frame_start_d;
    logic [3:0]    an_q, an_d;
    logic [6:0]    seg_q, seg_d;

    logic          tick_wrap;
    logic          frame_edge;
    logic [3:0]    nib;
    logic          blank;

    function automatic logic [6:0] hex_decode(input logic [3:0] n);
        logic [6:0] s;
        case (n)
            4'h0: s = 7'h40;
            4'h1: s = 7'h79;
            4'h2: s = 7'h24;
            4'h3: s = 7'h30;
            4'h4: s = 7'h19;
            4'h5: s = 7'h12;
            4'h6: s = 7'h02;
            4'h7: s = 7'h78;
            4'h8: s = 7'h00;
            4'h9: s = 7'h10;
            4'hA: s = 7'h08;
            4'hB: s = 7'h03;
            4'hC: s = 7'h46;
            4'hD: s = 7'h21;
            4'hE: s = 7'h06;
            default: s = 7'h0E;
        endcase
        return s;
    endfunction

    // Scan timing: the shadow reloads only on the digit-3 -> digit-0 edge so a frame never tears.
    always_comb begin
        tick_wrap     = (tick_cnt_q == TICK_LAST);
        frame_edge    = tick_wrap && (idx_q == 2'd3);
        tick_cnt_d    = tick_wrap ? '0 : tick_cnt_q + TW'(1);
        idx_d         = tick_wrap ? idx_q + 2'd1 : idx_q;
        shadow_d      = frame_edge ? disp.value_in : shadow_q;
        frame_start_d = frame_edge;
    end

    // A digit is blank when it and every nibble to its left are zero; digit 0 always shows.
    always_comb begin
        nib   = shadow_q[3:0];
        blank = 1'b0;
        case (idx_q)
            2'd1: begin
                nib   = shadow_q[7:4];
                blank = (BLANK_LEADING != 0) && (shadow_q[15:4] == 12'h000);
            end
            2'd2: begin
                nib   = shadow_q[11:8];
                blank = (BLANK_LEADING != 0) && (shadow_q[15:8] == 8'h00);
            end
            2'd3: begin
                nib   = shadow_q[15:12];
                blank = (BLANK_LEADING != 0) && (shadow_q[15:12] == 4'h0);
            end
            default: begin
                nib   = shadow_q[3:0];
                blank = 1'b0;
            end
        endcase
        an_d  = blank ? 4'b1111 : ~(4'b0001 << idx_q);
        seg_d = blank ? 7'h7F   : hex_decode(nib);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tick_cnt_q    <= '0;
            idx_q         <= 2'd0;
            shadow_q      <= 16'h0000;
            frame_start_q <= 1'b0;
            an_q          <= 4'b1111;
            seg_q         <= 7'h7F;
        end else begin
            tick_cnt_q    <= tick_cnt_d;
            idx_q         <= idx_d;
            shadow_q      <= shadow_d;
            frame_start_q <= frame_start_d;
            an_q          <= an_d;
            seg_q         <= seg_d;
        end
    end

    assign disp.an          = an_q;
    assign disp.seg         = seg_q;
    assign disp.dp          = 1'b1;
    assign disp.frame_start = frame_start_q;

endmodule

// File: tb/tb_seven_segment_scanner.sv
// Scoreboard bench for seven_segment_scanner with DIGIT_TICKS=4, one instance per blanking mode.
// Stimulus pushes per-cycle expectations; an independent monitor pops and compares every cycle.
module tb_seven_segment_scanner;

    logic        clk;
    logic        reset;
    logic [15:0] vin;
    logic        done;
    logic        mon_done;
    int          n_vec;
    int          n_err;

    typedef struct packed {
        logic [3:0] an1;
        logic [6:0] seg1;
        logic [3:0] an0;
        logic [6:0] seg0;
        logic       fs;
    } exp_t;

    exp_t sb_q [$];

    seven_segment_scanner_if d1_if ();
    seven_segment_scanner_if d0_if ();

    assign d1_if.value_in = vin;
    assign d0_if.value_in = vin;

    seven_segment_scanner #(.DIGIT_TICKS(4), .BLANK_LEADING(1)) dut_blank (
        .clk   (clk),
        .reset (reset),
        .disp  (d1_if.slave)
    );

    seven_segment_scanner #(.DIGIT_TICKS(4), .BLANK_LEADING(0)) dut_noblank (
        .clk   (clk),
        .reset (reset),
        .disp  (d0_if.slave)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Hand-decoded segment codes per frame, digit 0 first, and how many leading digits blank.
    logic [6:0]  tab_seg  [0:7][0:3] = '{
        '{7'h40, 7'h40, 7'h40, 7'h40},
        '{7'h19, 7'h30, 7'h24, 7'h79},
        '{7'h40, 7'h12, 7'h40, 7'h40},
        '{7'h79, 7'h79, 7'h79, 7'h79},
        '{7'h21, 7'h46, 7'h03, 7'h08},
        '{7'h78, 7'h40, 7'h40, 7'h40},
        '{7'h40, 7'h02, 7'h0E, 7'h00},
        '{7'h40, 7'h40, 7'h46, 7'h40}
    };
    int          tab_nb   [0:7] = '{3, 0, 2, 0, 0, 3, 0, 1};
    logic [15:0] tab_next [0:7] = '{16'h1234, 16'h0050, 16'h1111, 16'hABCD,
                                    16'h0007, 16'h8F60, 16'h0C00, 16'hFFFF};
    int          tab_cset [0:7] = '{1, 1, 1, 5, 1, 15, 1, 1};
    logic [3:0]  an_lit   [0:3] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};

    task automatic push_frame(input logic [6:0] s0, input logic [6:0] s1,
                              input logic [6:0] s2, input logic [6:0] s3, input int nb);
        logic [6:0] s [0:3];
        exp_t       e;
        int         k;
        bit         blk;
        s[0] = s0; s[1] = s1; s[2] = s2; s[3] = s3;
        for (int c = 1; c <= 16; c++) begin
            k      = (c - 1) / 4;
            blk    = (k != 0) && (k >= 4 - nb);
            e.an0  = an_lit[k];
            e.seg0 = s[k];
            e.an1  = blk ? 4'b1111 : an_lit[k];
            e.seg1 = blk ? 7'h7F : s[k];
            e.fs   = (c == 16);
            sb_q.push_back(e);
        end
    endtask

    task automatic chk(input string name, input logic [12:0] act, input logic [12:0] req);
        n_vec++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s @%0t: {an,seg,dp,fs} got %h required %h", name, $time, act, req);
        end
    endtask

    // Monitor: reset values whenever reset is high, otherwise one queued expectation per cycle.
    initial begin
        exp_t e;
        n_vec    = 0;
        n_err    = 0;
        mon_done = 1'b0;
        forever begin
            @(negedge clk or posedge reset);
            if (reset) begin
                #1;
                chk("reset_blank",   {d1_if.an, d1_if.seg, d1_if.dp, d1_if.frame_start},
                    {4'b1111, 7'h7F, 1'b1, 1'b0});
                chk("reset_noblank", {d0_if.an, d0_if.seg, d0_if.dp, d0_if.frame_start},
                    {4'b1111, 7'h7F, 1'b1, 1'b0});
            end else if (done) begin
                if (!mon_done) begin
                    chk("scoreboard_drained", 13'(sb_q.size()), 13'd0);
                    mon_done = 1'b1;
                end
            end else if (sb_q.size() > 0) begin
                e = sb_q.pop_front();
                chk("scan_blank",   {d1_if.an, d1_if.seg, d1_if.dp, d1_if.frame_start},
                    {e.an1, e.seg1, 1'b1, e.fs});
                chk("scan_noblank", {d0_if.an, d0_if.seg, d0_if.dp, d0_if.frame_start},
                    {e.an0, e.seg0, 1'b1, e.fs});
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: bench did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset = 1'b1;
        vin   = 16'h0000;
        done  = 1'b0;
        repeat (3) @(negedge clk);
        #1 reset = 1'b0;

        for (int f = 0; f < 8; f++) begin
            push_frame(tab_seg[f][0], tab_seg[f][1], tab_seg[f][2], tab_seg[f][3], tab_nb[f]);
            for (int c = 1; c <= 16; c++) begin
                @(negedge clk);
                #1;
                if (c == tab_cset[f]) vin = tab_next[f];
            end
        end

        // Frame of FFFF, interrupted by reset while digit 2 is being scanned.
        push_frame(7'h0E, 7'h0E, 7'h0E, 7'h0E, 0);
        for (int c = 1; c <= 9; c++) begin
            @(negedge clk);
            #1;
        end
        @(posedge clk);
        #3;
        reset = 1'b1;
        sb_q.delete();
        repeat (2) @(negedge clk);
        #1 reset = 1'b0;

        push_frame(7'h40, 7'h40, 7'h40, 7'h40, 3);
        push_frame(7'h0E, 7'h0E, 7'h0E, 7'h0E, 0);
        repeat (32) @(negedge clk);
        #1 done = 1'b1;
        repeat (3) @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
